// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle 32-bit SLL/SRL/SRA unit with a start/done handshake.
// One working register is shifted by one power-of-two stage (16, 8, 4, 2, 1)
// per cycle; the result register y is loaded only when the shift completes.
// Optional build macro: ITER_SHIFT_SKIP_EN
//   undefined : every shift walks all five stages (fixed 6-cycle latency).
//   defined   : only stages whose shamt bit is set are visited, highest first;
//               shamt == 0 completes straight from the capture cycle.
module iter_shifter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] B,
  input  logic [4:0]  shamt,
  input  logic [1:0]  ALUfun,
  output logic        busy,
  output logic        done,
  output logic [31:0] y
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] w_q, w_d;
  logic [2:0]  k_q, k_d;
  logic [4:0]  shamt_q, shamt_d;
  logic [1:0]  fun_q, fun_d;
  logic [31:0] y_q, y_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] stage_out;
  logic [4:0]  stage_amt;
`ifdef ITER_SHIFT_SKIP_EN
  logic [4:0]  rem_mask;
`endif

  // One shift stage by amount n. fun[1] selects arithmetic right shift
  // (sign bit taken from v as it stands now); otherwise fun[0] picks right/left.
  function automatic logic [31:0] shift_stage(input logic [31:0] v,
                                              input logic [4:0]  n,
                                              input logic [1:0]  fun);
    logic [31:0] r;
    case (fun)
      2'b00:        r = v << n;
      2'b01:        r = v >> n;
      2'b10, 2'b11: r = $unsigned($signed(v) >>> n);
      default:      r = v;
    endcase
    return r;
  endfunction

`ifdef ITER_SHIFT_SKIP_EN
  // Stage index (0 = 16, ..., 4 = 1) of the most significant set bit of m.
  // Scanning upward lets the highest set bit win; m == 0 yields 0.
  function automatic logic [2:0] top_stage(input logic [4:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 5; i++) begin
      r = m[i] ? (3'd4 - 3'(i)) : r;
    end
    return r;
  endfunction
`endif

  // Current stage amount and the working register shifted by it.
  always_comb begin
    stage_amt = 5'd16 >> k_q;
    stage_out = shift_stage(w_q, stage_amt, fun_q);
  end

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    k_d     = k_q;
    shamt_d = shamt_q;
    fun_d   = fun_q;
    y_d     = y_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef ITER_SHIFT_SKIP_EN
    rem_mask = 5'd0;
`endif

    case (state_q)
      // IDLE and DONE both accept a new request; DONE without start retires.
      S_IDLE, S_DONE: begin
        if (start) begin
          w_d     = B;
          shamt_d = shamt;
          fun_d   = ALUfun;
`ifdef ITER_SHIFT_SKIP_EN
          if (shamt == 5'd0) begin
            // Nothing to shift: the operand is the result.
            state_d = S_DONE;
            y_d     = B;
            k_d     = 3'd0;
          end else begin
            state_d = S_SHIFT;
            k_d     = top_stage(shamt);
          end
`else
          state_d = S_SHIFT;
          k_d     = 3'd0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SHIFT: begin
`ifdef ITER_SHIFT_SKIP_EN
        // k always points at a set bit here; retire it and seek the next one.
        w_d      = stage_out;
        rem_mask = shamt_q & ~(5'd1 << (3'd4 - k_q));
        shamt_d  = rem_mask;
        if (rem_mask == 5'd0) begin
          state_d = S_DONE;
          y_d     = stage_out;
          k_d     = 3'd0;
        end else begin
          state_d = S_SHIFT;
          k_d     = top_stage(rem_mask);
        end
`else
        if (shamt_q[3'd4 - k_q]) begin
          w_d = stage_out;
        end else begin
          w_d = w_q;
        end
        if (k_q == 3'd4) begin
          state_d = S_DONE;
          y_d     = w_d;
          k_d     = 3'd0;
        end else begin
          state_d = S_SHIFT;
          k_d     = k_q + 3'd1;
        end
`endif
      end

      default: begin
        state_d = S_IDLE;
        k_d     = 3'd0;
      end
    endcase

    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers; reset aborts any shift in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      w_q     <= 32'h0000_0000;
      k_q     <= 3'd0;
      shamt_q <= 5'd0;
      fun_q   <= 2'b00;
      y_q     <= 32'h0000_0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      k_q     <= k_d;
      shamt_q <= shamt_d;
      fun_q   <= fun_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign y    = y_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Testbench for iter_shifter: directed operations with literal expectations,
// plus a cycle-level reference model compared against the outputs every cycle.
module tb_iter_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] B;
  logic [4:0]  shamt;
  logic [1:0]  ALUfun;
  logic        busy;
  logic        done;
  logic [31:0] y;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

`ifdef ITER_SHIFT_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  // reference model state
  logic        m_busy;
  logic        m_done;
  logic [31:0] m_y;
  logic [31:0] m_res;
  int          m_cnt;

  iter_shifter dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .B      (B),
    .shamt  (shamt),
    .ALUfun (ALUfun),
    .busy   (busy),
    .done   (done),
    .y      (y)
  );

  always #5 clk = ~clk;

  // Plain shift result from the operation definition.
  function automatic logic [31:0] ref_shift(input logic [31:0] b,
                                            input logic [4:0] s,
                                            input logic [1:0] f);
    logic [31:0] r;
    if (f == 2'b00)      r = b << s;
    else if (f == 2'b01) r = b >> s;
    else                 r = $unsigned($signed(b) >>> s);
    return r;
  endfunction

  // Cycles from the start edge to the done cycle.
  function automatic int ref_lat(input logic [4:0] s);
    if (SKIP) return $countones(s) + 1;
    else      return 6;
  endfunction

  // Reference model: tracks result and remaining cycles at transaction level.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_y    <= 32'h0;
      m_res  <= 32'h0;
      m_cnt  <= 0;
    end else if (m_busy) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_y    <= m_res;
      end else begin
        m_done <= 1'b0;
      end
    end else if (start) begin
      m_res <= ref_shift(B, shamt, ALUfun);
      if (ref_lat(shamt) == 1) begin
        m_done <= 1'b1;
        m_y    <= ref_shift(B, shamt, ALUfun);
      end else begin
        m_busy <= 1'b1;
        m_done <= 1'b0;
        m_cnt  <= ref_lat(shamt) - 1;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      n_tests++;
      if ({busy, done, y} !== {m_busy, m_done, m_y}) begin
        n_fail++;
        $display("FAIL cycle_check t=%0t: got busy=%0b done=%0b y=%h, want busy=%0b done=%0b y=%h",
                 $time, busy, done, y, m_busy, m_done, m_y);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] b, input logic [4:0] s, input logic [1:0] f);
    B      = b;
    shamt  = s;
    ALUfun = f;
    start  = 1'b1;
  endtask

  // Waits (bounded) for done; checks latency counted from the start edge and y.
  task automatic wait_done(input string name, input logic [31:0] exp_y, input int exp_lat);
    int cnt;
    bit seen;
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        start = 1'b0;
        B     = ~B;        // operands need not stay stable after capture
        shamt = ~shamt;
      end
      if (done === 1'b1) seen = 1'b1;
    end
    check({name, "_lat"}, 32'(cnt), 32'(exp_lat));
    check({name, "_y"}, y, exp_y);
  endtask

  task automatic run_op(input string name, input logic [31:0] b, input logic [4:0] s,
                        input logic [1:0] f, input logic [31:0] exp_y, input int exp_lat);
    start_op(b, s, f);
    wait_done(name, exp_y, exp_lat);
    @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    B      = 32'h0;
    shamt  = 5'd0;
    ALUfun = 2'b00;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_y", y, 32'h0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    run_op("sll31",     32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 6);
    run_op("sra4",      32'h8000_0000, 5'd4,  2'b11, 32'hF800_0000, SKIP ? 2 : 6);
    run_op("sra4_f10",  32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000, SKIP ? 2 : 6);
    run_op("srl4",      32'h8000_0000, 5'd4,  2'b01, 32'h0800_0000, SKIP ? 2 : 6);
    run_op("srl16",     32'hF000_000F, 5'd16, 2'b01, 32'h0000_F000, SKIP ? 2 : 6);
    run_op("sll16",     32'hF000_000F, 5'd16, 2'b00, 32'h000F_0000, SKIP ? 2 : 6);
    run_op("sh0",       32'h1234_5678, 5'd0,  2'b00, 32'h1234_5678, SKIP ? 1 : 6);
    run_op("sra13",     32'hA5A5_A5A5, 5'd13, 2'b11, 32'hFFFD_2D2D, SKIP ? 4 : 6);
    run_op("sra31_pos", 32'h7FFF_0000, 5'd31, 2'b11, 32'h0000_0000, 6);

    // start while busy is ignored
    start_op(32'h0000_0003, 5'd30, 2'b00);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("ign_busy", {31'd0, busy}, 32'd1);
    start_op(32'hFFFF_FFFF, 5'd1, 2'b01);
    wait_done("ign_start", 32'hC000_0000, SKIP ? 3 : 4);
    repeat (3) @(negedge clk);
    check("ign_hold_y", y, 32'hC000_0000);

    // back-to-back: start held in the DONE cycle
    start_op(32'h8000_0000, 5'd31, 2'b11);
    wait_done("b2b_first", 32'hFFFF_FFFF, 6);
    start_op(32'h0F0F_0F0F, 5'd4, 2'b00);
    wait_done("b2b_second", 32'hF0F0_F0F0, SKIP ? 2 : 6);
    @(negedge clk);

    // asynchronous reset during the third SHIFT cycle
    start_op(32'hAAAA_5555, 5'd31, 2'b00);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_pre_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_y", y, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("after_rst", 32'hFFFF_FFFF, 5'd8, 2'b01, 32'h00FF_FFFF, SKIP ? 2 : 6);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
